// File: rtl/elastic_pipeline.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | elastic_pipeline: DEPTH-stage valid/ready register pipeline with bubble  |
// | collapse and flush. Optional ELASTIC_PIPELINE_OCCUPANCY_EN adds          |
// | occupancy_o/empty_o.                                     Revision: 1.0   |
// +--------------------------------------------------------------------------+
module elastic_pipeline #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 5
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [WIDTH-1:0]           input_val,
  input  logic                       pipe_in_valid,
  output logic                       pipe_in_rdy,
  output logic [WIDTH-1:0]           output_val,
  output logic                       pipe_out_valid,
  input  logic                       pipe_out_rdy,
  input  logic                       flush_i
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
  output logic                       empty_o
`endif
);

  logic [WIDTH-1:0] q_q [DEPTH];
  logic [WIDTH-1:0] q_d [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic             tail_full;
  logic             in_xfer;
  logic             out_xfer;

  // A stage may advance unless it and every stage after it is full while the
  // output is stalled; the running AND keeps the ready chain free of loops.
  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      tail_full = tail_full & v_q[k];
      adv[k]    = ~tail_full | pipe_out_rdy;
    end
  end

  assign pipe_in_rdy    = adv[0] & ~flush_i & ~reset_i;
  assign in_xfer        = pipe_in_valid & pipe_in_rdy;
  assign pipe_out_valid = v_q[DEPTH-1] & ~flush_i;
  assign out_xfer       = pipe_out_valid & pipe_out_rdy;
  assign output_val     = q_q[DEPTH-1];

  always_comb begin
    q_d = q_q;
    v_d = v_q;
    if (adv[0]) begin
      q_d[0] = input_val;
      v_d[0] = in_xfer;
    end
    for (int k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        q_d[k] = q_q[k-1];
        v_d[k] = v_q[k-1];
      end
    end
    if (flush_i) begin
      v_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        q_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      q_q <= q_d;
    end
  end

`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (flush_i) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy_o = occ_q;
  assign empty_o     = (occ_q == '0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipeline.sv
`default_nettype none
// Self-checking bench for elastic_pipeline: DEPTH=5 main instance plus a
// DEPTH=1 instance sharing the same stimulus.
module tb_elastic_pipeline;
  localparam int WIDTH = 5;
  localparam int DEPTH = 5;
  localparam int OW    = $clog2(DEPTH + 1);

  logic             clk_i = 1'b0;
  logic             reset_i = 1'b1;
  logic [WIDTH-1:0] input_val = '0;
  logic             pipe_in_valid = 1'b0;
  logic             pipe_out_rdy = 1'b0;
  logic             flush_i = 1'b0;
  logic             pipe_in_rdy;
  logic [WIDTH-1:0] output_val;
  logic             pipe_out_valid;
  logic             pipe_in_rdy1;
  logic [WIDTH-1:0] output_val1;
  logic             pipe_out_valid1;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
  logic [OW-1:0]    occupancy_o;
  logic             empty_o;
  logic [0:0]       occupancy1;
  logic             empty1;
`endif

  int               assert_cnt = 0;
  int               fail_cnt = 0;
  logic [WIDTH-1:0] exp_q [$];

  elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .input_val      (input_val),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_rdy    (pipe_in_rdy),
    .output_val     (output_val),
    .pipe_out_valid (pipe_out_valid),
    .pipe_out_rdy   (pipe_out_rdy),
    .flush_i        (flush_i)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy_o    (occupancy_o),
    .empty_o        (empty_o)
`endif
  );

  elastic_pipeline #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .input_val      (input_val),
    .pipe_in_valid  (pipe_in_valid),
    .pipe_in_rdy    (pipe_in_rdy1),
    .output_val     (output_val1),
    .pipe_out_valid (pipe_out_valid1),
    .pipe_out_rdy   (pipe_out_rdy),
    .flush_i        (flush_i)
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    ,
    .occupancy_o    (occupancy1),
    .empty_o        (empty1)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge reset_i) exp_q.delete();

  // Scoreboard: push on accepted input, pop and compare on delivered output.
  always @(negedge clk_i) begin
    if (reset_i || flush_i) begin
      exp_q.delete();
    end else begin
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
      assert_cnt++;
      if (occupancy_o !== OW'(exp_q.size()) || empty_o !== (exp_q.size() == 0)) begin
        fail_cnt++;
        $display("FAIL sb_occupancy: got occ=%0d empty=%b expected occ=%0d", occupancy_o, empty_o, exp_q.size());
      end
`endif
      if (pipe_out_valid && pipe_out_rdy) begin
        assert_cnt++;
        if (exp_q.size() == 0) begin
          fail_cnt++;
          $display("FAIL sb_unexpected: got output %h expected no output", output_val);
        end else begin
          logic [WIDTH-1:0] exp_v;
          exp_v = exp_q.pop_front();
          if (output_val !== exp_v) begin
            fail_cnt++;
            $display("FAIL sb_order: got %h expected %h", output_val, exp_v);
          end
        end
      end
      if (pipe_in_valid && pipe_in_rdy) exp_q.push_back(input_val);
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #3;
    assert_cnt++;
    if (pipe_out_valid !== 1'b0) begin fail_cnt++; $display("FAIL reset_out_valid: got %b expected 0", pipe_out_valid); end
    assert_cnt++;
    if (output_val !== '0) begin fail_cnt++; $display("FAIL reset_output_val: got %h expected 00", output_val); end
    assert_cnt++;
    if (pipe_in_rdy !== 1'b0) begin fail_cnt++; $display("FAIL reset_in_rdy: got %b expected 0", pipe_in_rdy); end
    tick();
    #2 reset_i = 1'b0;
    #1;
    assert_cnt++;
    if (pipe_in_rdy !== 1'b1) begin fail_cnt++; $display("FAIL reset_release_rdy: got %b expected 1", pipe_in_rdy); end
  endtask

  task automatic test_latency();
    logic exp0, exp1;
    pipe_out_rdy = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      if (e < 3) begin
        pipe_in_valid = 1'b1;
        input_val     = WIDTH'(e + 1);
      end else begin
        pipe_in_valid = 1'b0;
      end
      tick();
      exp0 = (e >= 4 && e <= 6);
      exp1 = (e <= 2);
      assert_cnt++;
      if (pipe_out_valid !== exp0) begin fail_cnt++; $display("FAIL latency_valid_d5 edge %0d: got %b expected %b", e, pipe_out_valid, exp0); end
      if (exp0) begin
        assert_cnt++;
        if (output_val !== WIDTH'(e - 3)) begin fail_cnt++; $display("FAIL latency_data_d5 edge %0d: got %h expected %h", e, output_val, WIDTH'(e - 3)); end
      end
      assert_cnt++;
      if (pipe_out_valid1 !== exp1) begin fail_cnt++; $display("FAIL latency_valid_d1 edge %0d: got %b expected %b", e, pipe_out_valid1, exp1); end
      if (exp1) begin
        assert_cnt++;
        if (output_val1 !== WIDTH'(e + 1)) begin fail_cnt++; $display("FAIL latency_data_d1 edge %0d: got %h expected %h", e, output_val1, WIDTH'(e + 1)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    pipe_out_rdy = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      pipe_in_valid = 1'b1;
      input_val     = WIDTH'(i);
      tick();
    end
    input_val = WIDTH'(6);
    for (int c = 0; c < 3; c++) begin
      assert_cnt++;
      if (pipe_in_rdy !== 1'b0) begin fail_cnt++; $display("FAIL full_in_rdy cycle %0d: got %b expected 0", c, pipe_in_rdy); end
      assert_cnt++;
      if (pipe_out_valid !== 1'b1 || output_val !== WIDTH'(1)) begin
        fail_cnt++; $display("FAIL stall_stable cycle %0d: got v=%b d=%h expected v=1 d=01", c, pipe_out_valid, output_val);
      end
      tick();
    end
    pipe_out_rdy = 1'b1;
    #1;
    assert_cnt++;
    if (pipe_in_rdy !== 1'b1) begin fail_cnt++; $display("FAIL release_in_rdy: got %b expected 1", pipe_in_rdy); end
    for (int i = 0; i < 5; i++) begin
      assert_cnt++;
      if (pipe_in_rdy !== 1'b1 || pipe_out_valid !== 1'b1) begin
        fail_cnt++; $display("FAIL throughput cycle %0d: got rdy=%b valid=%b expected 1 1", i, pipe_in_rdy, pipe_out_valid);
      end
      tick();
      input_val = WIDTH'(7 + i);
    end
    pipe_in_valid = 1'b0;
    repeat (8) tick();
    assert_cnt++;
    if (pipe_out_valid !== 1'b0 || exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL drain: got valid=%b pending=%0d expected 0 0", pipe_out_valid, exp_q.size());
    end
  endtask

  task automatic test_bubble();
    pipe_out_rdy  = 1'b0;
    pipe_in_valid = 1'b1;
    input_val     = WIDTH'(7);
    tick();
    pipe_in_valid = 1'b0;
    tick();
    tick();
    pipe_in_valid = 1'b1;
    input_val     = WIDTH'(9);
    tick();
    pipe_in_valid = 1'b0;
    repeat (4) tick();
    assert_cnt++;
    if (pipe_out_valid !== 1'b1 || output_val !== WIDTH'(7)) begin
      fail_cnt++; $display("FAIL bubble_head: got v=%b d=%h expected v=1 d=07", pipe_out_valid, output_val);
    end
    assert_cnt++;
    if (pipe_in_rdy !== 1'b1) begin fail_cnt++; $display("FAIL bubble_in_rdy: got %b expected 1", pipe_in_rdy); end
    pipe_out_rdy = 1'b1;
    tick();
    assert_cnt++;
    if (pipe_out_valid !== 1'b1 || output_val !== WIDTH'(9)) begin
      fail_cnt++; $display("FAIL bubble_second: got v=%b d=%h expected v=1 d=09", pipe_out_valid, output_val);
    end
    tick();
    assert_cnt++;
    if (pipe_out_valid !== 1'b0) begin fail_cnt++; $display("FAIL bubble_empty: got %b expected 0", pipe_out_valid); end
  endtask

  task automatic test_flush();
    pipe_out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pipe_in_valid = 1'b1;
      input_val     = WIDTH'(5'h11 + i);
      tick();
    end
    flush_i       = 1'b1;
    input_val     = WIDTH'(5'h1F);
    pipe_out_rdy  = 1'b1;
    #1;
    assert_cnt++;
    if (pipe_in_rdy !== 1'b0 || pipe_out_valid !== 1'b0) begin
      fail_cnt++; $display("FAIL flush_gate: got rdy=%b valid=%b expected 0 0", pipe_in_rdy, pipe_out_valid);
    end
    tick();
    flush_i       = 1'b0;
    pipe_in_valid = 1'b0;
`ifdef ELASTIC_PIPELINE_OCCUPANCY_EN
    assert_cnt++;
    if (occupancy_o !== '0 || empty_o !== 1'b1) begin
      fail_cnt++; $display("FAIL flush_occupancy: got occ=%0d empty=%b expected 0 1", occupancy_o, empty_o);
    end
`endif
    for (int c = 0; c < 8; c++) begin
      assert_cnt++;
      if (pipe_out_valid !== 1'b0) begin fail_cnt++; $display("FAIL flush_leak cycle %0d: got valid=%b d=%h expected 0", c, pipe_out_valid, output_val); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int n_out;
    pipe_out_rdy = 1'b1;
    for (int i = 0; i < 7; i++) begin
      pipe_in_valid = 1'b1;
      input_val     = WIDTH'(5'h15 + i);
      tick();
    end
    assert_cnt++;
    if (pipe_out_valid !== 1'b1) begin fail_cnt++; $display("FAIL midreset_pre: got %b expected 1", pipe_out_valid); end
    #2 reset_i = 1'b1;
    #1;
    assert_cnt++;
    if (pipe_out_valid !== 1'b0 || output_val !== '0 || pipe_in_rdy !== 1'b0) begin
      fail_cnt++; $display("FAIL midreset_async: got v=%b d=%h rdy=%b expected 0 00 0", pipe_out_valid, output_val, pipe_in_rdy);
    end
    assert_cnt++;
    if (pipe_out_valid1 !== 1'b0 || output_val1 !== '0) begin
      fail_cnt++; $display("FAIL midreset_async_d1: got v=%b d=%h expected 0 00", pipe_out_valid1, output_val1);
    end
    pipe_in_valid = 1'b0;
    tick();
    #2 reset_i = 1'b0;
    pipe_in_valid = 1'b1;
    input_val     = WIDTH'(5'h0A);
    #1;
    assert_cnt++;
    if (pipe_in_rdy !== 1'b1) begin fail_cnt++; $display("FAIL midreset_first_rdy: got %b expected 1", pipe_in_rdy); end
    tick();
    pipe_in_valid = 1'b0;
    n_out = 0;
    for (int c = 0; c < 8; c++) begin
      if (pipe_out_valid) n_out++;
      tick();
    end
    assert_cnt++;
    if (n_out != 1) begin fail_cnt++; $display("FAIL midreset_outputs: got %0d items expected 1", n_out); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_bubble();
    test_flush();
    test_reset_mid();
    assert_cnt++;
    if (exp_q.size() != 0) begin fail_cnt++; $display("FAIL final_pending: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
